// File: rtl/sdf_bitrev_reorder_pkg.sv
// Shared types and default sizing for the SDF bit-reverse output reorder stage.
package sdf_bitrev_reorder_pkg;

    localparam int unsigned DEF_LOG2N = 3;
    localparam int unsigned DEF_DW    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } rd_state_e;

endpackage

// File: rtl/bitrev_dpram.sv
// Two-bank frame buffer: one write port and a registered-address synchronous read port.
// The array has no reset, so it can map onto block RAM.
module bitrev_dpram #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] raddr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            raddr_q <= raddr;
        end
    end

    assign rdata_c = mem[raddr_q];

endmodule

// File: rtl/sdf_bitrev_reorder.sv
// Reorders bit-reversed SDF FFT frames into natural order through a ping-pong buffer.
// Adds one frame plus one cycle of latency and streams back-to-back frames without gaps.
module sdf_bitrev_reorder
    import sdf_bitrev_reorder_pkg::*;
#(
    parameter int unsigned LOG2N = DEF_LOG2N,
    parameter int unsigned DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          di_en,
    input  logic [DW-1:0] di_re,
    input  logic [DW-1:0] di_im,
    output logic          do_en,
    output logic [DW-1:0] do_re,
    output logic [DW-1:0] do_im,
    output logic          do_last,
    output logic          ovf
);

    localparam int unsigned N  = 2 ** LOG2N;
    localparam int unsigned AW = LOG2N + 1;
    localparam int unsigned MW = 2 * DW;
    localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [LOG2N-1:0] wcnt;
    logic             wbank;
    logic [LOG2N-1:0] rcnt, rcnt_nxt;
    logic             rbank, rbank_nxt;
    logic [1:0]       full, full_nxt;
    rd_state_e        state, state_nxt;

    logic             wr_last_c, rd_last_c;
    logic             ovf_nxt, do_en_nxt, do_last_nxt;
    logic             rd_en_c;
    logic [AW-1:0]    waddr_c, raddr_c;
    logic [MW-1:0]    rdata_c;

    assign wr_last_c = di_en && (wcnt == CNT_MAX);
    assign rd_last_c = (state == ST_READ) && (rcnt == CNT_MAX);
    assign waddr_c   = {wbank, bitrev(wcnt)};
    assign raddr_c   = {rbank_nxt, rcnt_nxt};
    assign rd_en_c   = (state_nxt == ST_READ);

    // Write counter: a di_en gap drops any partial frame, matching the upstream SDF counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt  <= '0;
            wbank <= 1'b0;
        end else if (di_en) begin
            wcnt <= wcnt + LOG2N'(1);
            if (wr_last_c) begin
                wbank <= ~wbank;
            end
        end else begin
            wcnt <= '0;
        end
    end

    // Set after clear so a frame landing in a bank freed on the same edge stays full.
    always_comb begin
        full_nxt = full;
        if (rd_last_c) begin
            full_nxt[rbank] = 1'b0;
        end
        if (wr_last_c) begin
            full_nxt[wbank] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            rcnt  <= '0;
            rbank <= 1'b0;
            full  <= 2'b00;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            rbank <= rbank_nxt;
            full  <= full_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        rbank_nxt = rbank;
        case (state)
            ST_IDLE: begin
                if (full[rbank]) begin
                    state_nxt = ST_READ;
                    rcnt_nxt  = '0;
                end
            end
            ST_READ: begin
                rcnt_nxt = rcnt + LOG2N'(1);
                if (rcnt == CNT_MAX) begin
                    rbank_nxt = ~rbank;
                    if (!full_nxt[~rbank]) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode; the RAM address registered last edge yields X[rcnt] now.
    always_comb begin
        do_en_nxt   = (state == ST_READ);
        do_last_nxt = rd_last_c;
        ovf_nxt     = ovf | (wr_last_c && full[wbank] && !(rd_last_c && (rbank == wbank)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_en   <= 1'b0;
            do_last <= 1'b0;
            do_re   <= '0;
            do_im   <= '0;
        end else begin
            do_en   <= do_en_nxt;
            do_last <= do_last_nxt;
            if (do_en_nxt) begin
                do_re <= rdata_c[MW-1:DW];
                do_im <= rdata_c[DW-1:0];
            end
        end
    end

    bitrev_dpram #(
        .AW(AW),
        .DW(MW)
    ) u_ram (
        .clk    (clk),
        .we     (di_en),
        .waddr  (waddr_c),
        .wdata  ({di_re, di_im}),
        .re     (rd_en_c),
        .raddr  (raddr_c),
        .rdata_c(rdata_c)
    );

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Bench for sdf_bitrev_reorder: N=8 and N=16 instances against a frame-level reference model.
module tb_sdf_bitrev_reorder;

    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en8, en16;
    logic [DW-1:0] re8, im8, re16, im16;
    logic          oen8, olast8, ovf8, oen16, olast16, ovf16;
    logic [DW-1:0] ore8, oim8, ore16, oim16;

    always #5 clk = ~clk;

    sdf_bitrev_reorder #(.LOG2N(3), .DW(DW)) dut8 (
        .clk(clk), .rst(rst), .di_en(en8), .di_re(re8), .di_im(im8),
        .do_en(oen8), .do_re(ore8), .do_im(oim8), .do_last(olast8), .ovf(ovf8)
    );

    sdf_bitrev_reorder #(.LOG2N(4), .DW(DW)) dut16 (
        .clk(clk), .rst(rst), .di_en(en16), .di_re(re16), .di_im(im16),
        .do_en(oen16), .do_re(ore16), .do_im(oim16), .do_last(olast16), .ovf(ovf16)
    );

    typedef struct {
        int            e;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] fre[16];
    logic [DW-1:0] fim[16];
    logic [DW-1:0] cap_re[$];
    logic [DW-1:0] cap_im[$];
    int            wpos, nsz, lg, last_out, ecnt, vec, errs, nlast, first_en, s0;
    bit            sel16;
    int            exp8[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};
    int            exp16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    function automatic int bit_rev(int v, int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // A frame whose last sample lands at edge e comes out 2 edges later, or right after the previous frame.
    task automatic schedule(int e);
        int start;
        start = (e <= last_out) ? last_out + 1 : e + 2;
        for (int k = 0; k < nsz; k++) begin
            q.push_back('{start + k, fre[bit_rev(k, lg)], fim[bit_rev(k, lg)], (k == nsz - 1)});
        end
        last_out = start + nsz - 1;
    endtask

    task automatic check();
        logic          o_en, o_last, o_ovf, exp_en;
        logic [DW-1:0] o_re, o_im;
        o_en   = sel16 ? oen16 : oen8;
        o_last = sel16 ? olast16 : olast8;
        o_ovf  = sel16 ? ovf16 : ovf8;
        o_re   = sel16 ? ore16 : ore8;
        o_im   = sel16 ? oim16 : oim8;
        while (q.size() > 0 && q[0].e < ecnt) void'(q.pop_front());
        exp_en = (q.size() > 0 && q[0].e == ecnt);
        vec++;
        assert (o_en === exp_en) else begin
            errs++;
            $error("FAIL do_en edge %0d: observed %b expected %b", ecnt, o_en, exp_en);
        end
        if (o_en === 1'b1) begin
            cap_re.push_back(o_re);
            cap_im.push_back(o_im);
            if (o_last === 1'b1) nlast++;
            if (first_en < 0) first_en = ecnt;
        end
        if (exp_en) begin
            vec++;
            assert ({o_re, o_im, o_last} === {q[0].re, q[0].im, q[0].last}) else begin
                errs++;
                $error("FAIL data edge %0d: observed re=%0d im=%0d last=%b expected re=%0d im=%0d last=%b",
                       ecnt, o_re, o_im, o_last, q[0].re, q[0].im, q[0].last);
            end
            void'(q.pop_front());
        end
        vec++;
        assert (o_ovf === 1'b0) else begin
            errs++;
            $error("FAIL ovf edge %0d: observed %b expected 0", ecnt, o_ovf);
        end
    endtask

    // Present one input cycle, advance one edge, update the model, then check outputs.
    task automatic drive(logic en, logic [DW-1:0] r, logic [DW-1:0] i);
        if (sel16) begin
            en16 = en; re16 = r; im16 = i;
        end else begin
            en8 = en; re8 = r; im8 = i;
        end
        @(posedge clk);
        ecnt++;
        if (en) begin
            fre[wpos] = r;
            fim[wpos] = i;
            wpos++;
            if (wpos == nsz) begin
                wpos = 0;
                schedule(ecnt);
            end
        end else begin
            wpos = 0;
        end
        #1;
        check();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < nsz; i++) drive(1'b1, DW'($urandom), DW'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en8 = 1'b0; re8 = '0; im8 = '0;
        en16 = 1'b0; re16 = '0; im16 = '0;
        #1;
        vec++;
        assert ({oen8, ore8, oim8, olast8, ovf8, oen16, ore16, oim16, olast16, ovf16} === '0) else begin
            errs++;
            $error("FAIL reset_outputs: observed en=%b re=%0d im=%0d last=%b ovf=%b expected all 0",
                   oen8, ore8, oim8, olast8, ovf8);
        end
        q.delete();
        wpos     = 0;
        last_out = -100;
        @(posedge clk);
        ecnt++;
        #1;
        rst = 1'b0;
    endtask

    task automatic flush_check(string tag, int want_last);
        idle(int'(nsz) + 6);
        vec++;
        assert (q.size() == 0) else begin
            errs++;
            $error("FAIL %s_drain: observed %0d pending outputs expected 0", tag, q.size());
        end
        vec++;
        assert (nlast == want_last) else begin
            errs++;
            $error("FAIL %s_last_count: observed %0d expected %0d", tag, nlast, want_last);
        end
    endtask

    task automatic clear_caps();
        cap_re.delete();
        cap_im.delete();
        nlast    = 0;
        first_en = -1;
    endtask

    initial begin
        vec = 0; errs = 0; ecnt = 0; sel16 = 1'b0; nsz = 8; lg = 3;
        rst = 1'b1;
        en8 = 1'b0; re8 = '0; im8 = '0; en16 = 1'b0; re16 = '0; im16 = '0;
        repeat (3) @(posedge clk);
        do_reset();

        // Single directed frame.
        clear_caps();
        s0 = ecnt + 1;
        for (int i = 0; i < 8; i++) drive(1'b1, DW'(i), DW'(100 + i));
        flush_check("single", 1);
        vec++;
        assert (first_en - s0 == 9) else begin
            errs++;
            $error("FAIL single_latency: observed %0d expected 9", first_en - s0);
        end
        for (int k = 0; k < 8; k++) begin
            vec++;
            assert (cap_re.size() == 8 && cap_re[k] === DW'(exp8[k]) && cap_im[k] === DW'(100 + exp8[k])) else begin
                errs++;
                $error("FAIL single_order[%0d]: observed re=%0d expected re=%0d", k,
                       (cap_re.size() > k) ? cap_re[k] : 'x, exp8[k]);
            end
        end

        // Four back-to-back random frames.
        clear_caps();
        repeat (4) rand_frame();
        flush_check("b2b", 4);
        vec++;
        assert (cap_re.size() == 32) else begin
            errs++;
            $error("FAIL b2b_count: observed %0d expected 32", cap_re.size());
        end

        // Partial frame is discarded.
        clear_caps();
        for (int i = 0; i < 5; i++) drive(1'b1, DW'($urandom), DW'($urandom));
        idle(2);
        rand_frame();
        flush_check("partial", 1);

        // Frame, 3 idle cycles, frame.
        clear_caps();
        rand_frame();
        idle(3);
        rand_frame();
        flush_check("gap", 2);

        // Reset while reading, then a fresh frame.
        clear_caps();
        rand_frame();
        for (int i = 0; i < 40 && cap_re.size() < 3; i++) idle(1);
        vec++;
        assert (cap_re.size() >= 3) else begin
            errs++;
            $error("FAIL midreset_wait: observed %0d outputs expected 3", cap_re.size());
        end
        do_reset();
        clear_caps();
        s0 = ecnt + 1;
        rand_frame();
        flush_check("post_reset", 1);
        vec++;
        assert (first_en - s0 == 9) else begin
            errs++;
            $error("FAIL post_reset_latency: observed %0d expected 9", first_en - s0);
        end

        // Random di_en traffic with gaps and partial frames.
        clear_caps();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 99) < 85), DW'($urandom), DW'($urandom));
        end
        idle(20);
        vec++;
        assert (q.size() == 0) else begin
            errs++;
            $error("FAIL random_drain: observed %0d pending expected 0", q.size());
        end

        // N=16 ramp.
        sel16 = 1'b1; nsz = 16; lg = 4;
        do_reset();
        clear_caps();
        for (int i = 0; i < 16; i++) drive(1'b1, DW'(i), DW'($urandom));
        flush_check("n16", 1);
        for (int k = 0; k < 16; k++) begin
            vec++;
            assert (cap_re.size() == 16 && cap_re[k] === DW'(exp16[k])) else begin
                errs++;
                $error("FAIL n16_order[%0d]: observed re=%0d expected re=%0d", k,
                       (cap_re.size() > k) ? cap_re[k] : 'x, exp16[k]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
